dram_request_arbiter: RTL and testbench

DRAM_REQUEST_ARBITER -- requirements
Module: DRAM_RequestArbiter

---
 rtl/dram_request_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dram_request_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_request_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto a single DRAM port with
// one transaction in flight, round-robin tie-breaking and a response timeout.
module dram_request_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  negResetIn,
  input  logic                  icReqValid,
  output logic                  icReqReady,
  input  logic [ADDR_WIDTH-1:0] icReqAddr,
  output logic                  icRespValid,
  output logic [LINE_WIDTH-1:0] icRespData,
  input  logic                  dcReqValid,
  output logic                  dcReqReady,
  input  logic                  dcReqWrite,
  input  logic [ADDR_WIDTH-1:0] dcReqAddr,
  input  logic [LINE_WIDTH-1:0] dcReqData,
  output logic                  dcRespValid,
  output logic [LINE_WIDTH-1:0] dcRespData,
  output logic                  memReqValid,
  output logic                  memReqWrite,
  output logic [ADDR_WIDTH-1:0] memReqAddr,
  output logic [LINE_WIDTH-1:0] memReqData,
  input  logic                  memReqReady,
  input  logic                  memRespValid,
  input  logic [LINE_WIDTH-1:0] memRespData,
  output logic                  busy,
  output logic                  timeoutErr
);

  localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic                    write_reg, write_next;
  logic [LINE_WIDTH-1:0]   data_reg, data_next;
  logic                    owner_reg, owner_next;     // 1 = D-cache
  logic                    rr_ptr_reg, rr_ptr_next;   // 1 = D-cache wins a tie
  logic [TIMER_WIDTH-1:0]  timer_reg, timer_next;
  logic                    timeout_err_reg, timeout_err_next;
  logic                    ic_resp_valid_reg, ic_resp_valid_next;
  logic                    dc_resp_valid_reg, dc_resp_valid_next;
  logic [LINE_WIDTH-1:0]   ic_resp_data_reg, ic_resp_data_next;
  logic [LINE_WIDTH-1:0]   dc_resp_data_reg, dc_resp_data_next;

  logic                    dc_sel;
  logic                    ic_grant, dc_grant;
  logic                    finish;
  logic [LINE_WIDTH-1:0]   finish_data;

  assign dc_sel   = dcReqValid && (!icReqValid || rr_ptr_reg);
  assign ic_grant = (state_reg == IDLE) && icReqValid && !dc_sel;
  assign dc_grant = (state_reg == IDLE) && dc_sel;

  // Readys are gated by reset so every output is low while reset is held.
  assign icReqReady  = ic_grant && negResetIn;
  assign dcReqReady  = dc_grant && negResetIn;
  assign memReqValid = (state_reg == ISSUE);
  assign memReqWrite = write_reg;
  assign memReqAddr  = addr_reg;
  assign memReqData  = data_reg;
  assign busy        = (state_reg != IDLE);
  assign timeoutErr  = timeout_err_reg;
  assign icRespValid = ic_resp_valid_reg;
  assign icRespData  = ic_resp_data_reg;
  assign dcRespValid = dc_resp_valid_reg;
  assign dcRespData  = dc_resp_data_reg;

  always_ff @(posedge clk or negedge negResetIn) begin
    if (!negResetIn) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      write_reg         <= 1'b0;
      data_reg          <= '0;
      owner_reg         <= 1'b0;
      rr_ptr_reg        <= 1'b0;
      timer_reg         <= '0;
      timeout_err_reg   <= 1'b0;
      ic_resp_valid_reg <= 1'b0;
      dc_resp_valid_reg <= 1'b0;
      ic_resp_data_reg  <= '0;
      dc_resp_data_reg  <= '0;
    end else begin
      state_reg         <= state_next;
      addr_reg          <= addr_next;
      write_reg         <= write_next;
      data_reg          <= data_next;
      owner_reg         <= owner_next;
      rr_ptr_reg        <= rr_ptr_next;
      timer_reg         <= timer_next;
      timeout_err_reg   <= timeout_err_next;
      ic_resp_valid_reg <= ic_resp_valid_next;
      dc_resp_valid_reg <= dc_resp_valid_next;
      ic_resp_data_reg  <= ic_resp_data_next;
      dc_resp_data_reg  <= dc_resp_data_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    addr_next          = addr_reg;
    write_next         = write_reg;
    data_next          = data_reg;
    owner_next         = owner_reg;
    rr_ptr_next        = rr_ptr_reg;
    timer_next         = timer_reg;
    timeout_err_next   = timeout_err_reg;
    ic_resp_valid_next = 1'b0;
    dc_resp_valid_next = 1'b0;
    ic_resp_data_next  = ic_resp_data_reg;
    dc_resp_data_next  = dc_resp_data_reg;
    finish             = 1'b0;
    finish_data        = '0;

    case (state_reg)
      IDLE: begin
        if (dc_grant) begin
          addr_next  = dcReqAddr;
          write_next = dcReqWrite;
          data_next  = dcReqData;
          owner_next = 1'b1;
          state_next = ISSUE;
        end else if (ic_grant) begin
          addr_next  = icReqAddr;
          write_next = 1'b0;
          data_next  = '0;
          owner_next = 1'b0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (memReqReady) begin
          state_next = WAIT;
          timer_next = '0;
        end
      end
      WAIT: begin
        // A response arriving on the last timer cycle beats the timeout.
        if (memRespValid) begin
          finish      = 1'b1;
          finish_data = memRespData;
        end else if (timer_reg == TIMER_LAST) begin
          finish           = 1'b1;
          timeout_err_next = 1'b1;
        end else begin
          timer_next = timer_reg + TIMER_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (finish) begin
      state_next  = IDLE;
      rr_ptr_next = !owner_reg;
      if (owner_reg) begin
        dc_resp_valid_next = 1'b1;
        dc_resp_data_next  = finish_data;
      end else begin
        ic_resp_valid_next = 1'b1;
        ic_resp_data_next  = finish_data;
      end
    end
  end

endmodule

// File: tb/tb_dram_request_arbiter.sv
// Directed bench for dram_request_arbiter: arbitration order, stalls,
// timeout, async reset abort and response/timeout collision.
module tb_dram_request_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          negResetIn;
  logic          icReqValid, icReqReady, icRespValid;
  logic [AW-1:0] icReqAddr;
  logic [LW-1:0] icRespData;
  logic          dcReqValid, dcReqReady, dcReqWrite, dcRespValid;
  logic [AW-1:0] dcReqAddr;
  logic [LW-1:0] dcReqData, dcRespData;
  logic          memReqValid, memReqWrite, memReqReady, memRespValid;
  logic [AW-1:0] memReqAddr;
  logic [LW-1:0] memReqData, memRespData;
  logic          busy, timeoutErr;

  int n_cmp = 0;
  int n_err = 0;

  dram_request_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .negResetIn(negResetIn),
    .icReqValid(icReqValid), .icReqReady(icReqReady), .icReqAddr(icReqAddr),
    .icRespValid(icRespValid), .icRespData(icRespData),
    .dcReqValid(dcReqValid), .dcReqReady(dcReqReady), .dcReqWrite(dcReqWrite),
    .dcReqAddr(dcReqAddr), .dcReqData(dcReqData),
    .dcRespValid(dcRespValid), .dcRespData(dcRespData),
    .memReqValid(memReqValid), .memReqWrite(memReqWrite), .memReqAddr(memReqAddr),
    .memReqData(memReqData), .memReqReady(memReqReady),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LW-1:0] a5, d1, d2, wd, ak, c3;
    a5 = {16{8'hA5}};
    d1 = {4{32'h1111_0001}};
    d2 = {4{32'h2222_0002}};
    wd = {4{32'hDEAD_BEEF}};
    ak = {4{32'h0000_ACED}};
    c3 = {16{8'hC3}};

    negResetIn = 1'b0;
    icReqValid = 1'b1; icReqAddr = '0;
    dcReqValid = 1'b0; dcReqWrite = 1'b0; dcReqAddr = '0; dcReqData = '0;
    memReqReady = 1'b0; memRespValid = 1'b0; memRespData = '0;
    #2;
    $display("step: reset state");
    chk("rst_busy", LW'(busy), LW'(0));
    chk("rst_memReqValid", LW'(memReqValid), LW'(0));
    chk("rst_icReqReady", LW'(icReqReady), LW'(0));
    chk("rst_timeoutErr", LW'(timeoutErr), LW'(0));
    chk("rst_icRespValid", LW'(icRespValid), LW'(0));
    icReqValid = 1'b0;
    tick(); tick();
    negResetIn = 1'b1;
    tick();

    // Tie after reset: I-cache first, D-cache next, then I-cache again.
    $display("step: tie arbitration");
    icReqValid = 1'b1; icReqAddr = 32'h3000;
    dcReqValid = 1'b1; dcReqAddr = 32'h4000; dcReqWrite = 1'b0;
    memReqReady = 1'b1;
    #1;
    chk("tie1_icReqReady", LW'(icReqReady), LW'(1));
    chk("tie1_dcReqReady", LW'(dcReqReady), LW'(0));
    tick();
    icReqValid = 1'b0;
    #1;
    chk("tie1_memReqValid", LW'(memReqValid), LW'(1));
    chk("tie1_memReqAddr", LW'(memReqAddr), LW'(32'h3000));
    chk("tie1_dcReqReady_busy", LW'(dcReqReady), LW'(0));
    tick();
    memRespValid = 1'b1; memRespData = d1;
    tick();
    memRespValid = 1'b0;
    #1;
    chk("tie1_icRespValid", LW'(icRespValid), LW'(1));
    chk("tie1_icRespData", icRespData, d1);
    chk("tie1_busy_after", LW'(busy), LW'(0));
    chk("tie2_dcReqReady_nobubble", LW'(dcReqReady), LW'(1));
    tick();
    dcReqValid = 1'b0;
    #1;
    chk("tie2_memReqAddr", LW'(memReqAddr), LW'(32'h4000));
    chk("tie2_memReqWrite", LW'(memReqWrite), LW'(0));
    chk("tie2_icRespValid_pulse", LW'(icRespValid), LW'(0));
    tick();
    memRespValid = 1'b1; memRespData = d2;
    tick();
    memRespValid = 1'b0;
    #1;
    chk("tie2_dcRespValid", LW'(dcRespValid), LW'(1));
    chk("tie2_dcRespData", dcRespData, d2);
    chk("tie2_icRespValid", LW'(icRespValid), LW'(0));
    chk("tie2_icRespData_held", icRespData, d1);
    tick();
    icReqValid = 1'b1; dcReqValid = 1'b1;
    #1;
    chk("tie3_icReqReady", LW'(icReqReady), LW'(1));
    chk("tie3_dcReqReady", LW'(dcReqReady), LW'(0));
    #1;
    icReqValid = 1'b0; dcReqValid = 1'b0;
    tick();

    // I-cache read, response three cycles after the issue handshake.
    $display("step: icache read 0x1000");
    icReqValid = 1'b1; icReqAddr = 32'h1000;
    #1;
    chk("ic_icReqReady", LW'(icReqReady), LW'(1));
    tick();
    icReqValid = 1'b0;
    #1;
    chk("ic_memReqValid", LW'(memReqValid), LW'(1));
    chk("ic_memReqAddr", LW'(memReqAddr), LW'(32'h1000));
    chk("ic_busy", LW'(busy), LW'(1));
    tick();
    memReqReady = 1'b0;
    #1;
    chk("ic_wait_memReqValid", LW'(memReqValid), LW'(0));
    tick();
    tick();
    memRespValid = 1'b1; memRespData = a5;
    #1;
    chk("ic_no_early_resp", LW'(icRespValid), LW'(0));
    tick();
    memRespValid = 1'b0;
    #1;
    chk("ic_icRespValid", LW'(icRespValid), LW'(1));
    chk("ic_icRespData", icRespData, a5);
    chk("ic_dcRespValid", LW'(dcRespValid), LW'(0));
    chk("ic_busy_after", LW'(busy), LW'(0));
    tick();
    chk("ic_icRespValid_pulse", LW'(icRespValid), LW'(0));
    chk("ic_icRespData_held", icRespData, a5);

    // D-cache write stalled for five cycles by memReqReady.
    $display("step: dcache write 0x2000 with stall");
    dcReqValid = 1'b1; dcReqWrite = 1'b1; dcReqAddr = 32'h2000; dcReqData = wd;
    memReqReady = 1'b0;
    #1;
    chk("wr_dcReqReady", LW'(dcReqReady), LW'(1));
    tick();
    dcReqValid = 1'b0; dcReqData = '1; dcReqAddr = 32'hFFFF_FFFF; icReqValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      $display("step: stall cycle %0d", k);
      chk("wr_stall_memReqValid", LW'(memReqValid), LW'(1));
      chk("wr_stall_memReqAddr", LW'(memReqAddr), LW'(32'h2000));
      chk("wr_stall_memReqWrite", LW'(memReqWrite), LW'(1));
      chk("wr_stall_memReqData", memReqData, wd);
      chk("wr_stall_icReqReady", LW'(icReqReady), LW'(0));
      chk("wr_stall_dcReqReady", LW'(dcReqReady), LW'(0));
      tick();
    end
    memReqReady = 1'b1; icReqValid = 1'b0;
    tick();
    memReqReady = 1'b0; memRespValid = 1'b1; memRespData = ak;
    tick();
    memRespValid = 1'b0;
    #1;
    chk("wr_dcRespValid", LW'(dcRespValid), LW'(1));
    chk("wr_dcRespData", dcRespData, ak);
    chk("wr_icRespValid", LW'(icRespValid), LW'(0));
    tick();
    chk("wr_dcRespValid_pulse", LW'(dcRespValid), LW'(0));

    // Timeout after 16 WAIT cycles without a response.
    $display("step: timeout");
    icReqValid = 1'b1; icReqAddr = 32'h5000; memReqReady = 1'b1;
    tick();
    icReqValid = 1'b0;
    tick();
    memReqReady = 1'b0;
    for (int k = 0; k < TO; k++) begin
      #1;
      chk("to_wait_busy", LW'(busy), LW'(1));
      chk("to_wait_icRespValid", LW'(icRespValid), LW'(0));
      chk("to_wait_timeoutErr", LW'(timeoutErr), LW'(0));
      tick();
    end
    #1;
    chk("to_timeoutErr", LW'(timeoutErr), LW'(1));
    chk("to_icRespValid", LW'(icRespValid), LW'(1));
    chk("to_icRespData_zero", icRespData, LW'(0));
    chk("to_busy", LW'(busy), LW'(0));
    memRespValid = 1'b1; memRespData = c3;
    tick();
    memRespValid = 1'b0;
    #1;
    chk("to_late_icRespValid", LW'(icRespValid), LW'(0));
    chk("to_late_dcRespValid", LW'(dcRespValid), LW'(0));
    chk("to_late_busy", LW'(busy), LW'(0));
    chk("to_sticky", LW'(timeoutErr), LW'(1));

    // Asynchronous reset in WAIT aborts the transaction.
    $display("step: reset during wait");
    dcReqValid = 1'b1; dcReqWrite = 1'b0; dcReqAddr = 32'h6000; memReqReady = 1'b1;
    tick();
    dcReqValid = 1'b0;
    tick();
    memReqReady = 1'b0;
    #1;
    chk("ar_wait_busy", LW'(busy), LW'(1));
    tick();
    negResetIn = 1'b0;
    #1;
    chk("ar_busy", LW'(busy), LW'(0));
    chk("ar_timeoutErr", LW'(timeoutErr), LW'(0));
    chk("ar_dcRespValid", LW'(dcRespValid), LW'(0));
    chk("ar_dcRespData", dcRespData, LW'(0));
    chk("ar_icRespData", icRespData, LW'(0));
    memRespValid = 1'b1; memRespData = d2;
    tick();
    negResetIn = 1'b1;
    tick();
    memRespValid = 1'b0;
    #1;
    chk("ar_late_dcRespValid", LW'(dcRespValid), LW'(0));
    chk("ar_late_icRespValid", LW'(icRespValid), LW'(0));
    chk("ar_late_busy", LW'(busy), LW'(0));

    // Response on the last WAIT cycle wins over the timeout.
    $display("step: response vs timeout collision");
    icReqValid = 1'b1; icReqAddr = 32'h7000; memReqReady = 1'b1;
    #1;
    chk("col_icReqReady", LW'(icReqReady), LW'(1));
    tick();
    icReqValid = 1'b0;
    #1;
    chk("col_memReqAddr", LW'(memReqAddr), LW'(32'h7000));
    tick();
    memReqReady = 1'b0;
    for (int k = 0; k < TO - 1; k++) tick();
    memRespValid = 1'b1; memRespData = c3;
    tick();
    memRespValid = 1'b0;
    #1;
    chk("col_icRespValid", LW'(icRespValid), LW'(1));
    chk("col_icRespData", icRespData, c3);
    chk("col_timeoutErr", LW'(timeoutErr), LW'(0));
    chk("col_busy", LW'(busy), LW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
